// File: rtl/seg_scan_pkg.sv
// Shared constants and scan-state encoding for the seven-segment scan controller.
package seg_scan_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StGuard
  } scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake between the value producer (master) and the scan controller (slave).
interface seg_scan_ctrl_if
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
);

  logic [DIGIT_W*NUM_DIGITS-1:0] value_in;
  logic                          load_req;
  logic                          load_ack;

  modport master (
    output value_in,
    output load_req,
    input  load_ack
  );

  modport slave (
    input  value_in,
    input  load_req,
    output load_ack
  );

endinterface

// File: rtl/seg_tick_div.sv
// Loadable down-counter; tc is high while the count sits at zero.
module seg_tick_div #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multi-digit seven-segment scan controller with tear-free shadow loading at frame wrap.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned GUARD_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  seg_scan_ctrl_if.slave        ld,
  output logic [DIGIT_W-1:0]    digit_code,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_start
);

  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned MAX_CNT = (TICK_DIV > GUARD_CYC) ? TICK_DIV : GUARD_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] TICK_LD  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LD = (GUARD_CYC > 0) ? CNT_W'(GUARD_CYC - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_e                   state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [DIGIT_W*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                          ack_d, fs_d, next_slot;
  logic                          cnt_clr, cnt_load, tc;
  logic [CNT_W-1:0]              cnt_val;
  logic [NUM_DIGITS-1:0]         blank, an_n_d;
  logic [DIGIT_W-1:0]            code_d;

  seg_tick_div #(
    .CNT_W(CNT_W)
  ) u_tick_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .load    (cnt_load),
    .load_val(cnt_val),
    .tc      (tc)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    ack_d     = 1'b0;
    fs_d      = 1'b0;
    next_slot = 1'b0;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = TICK_LD;
    unique case (state_q)
      StIdle: begin
        if (ld.load_req) begin
          shadow_d = ld.value_in;
          ack_d    = 1'b1;
        end
        if (enable) begin
          state_d  = StScan;
          idx_d    = '0;
          fs_d     = 1'b1;
          cnt_load = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      StScan: begin
        if (!enable) begin
          state_d = StIdle;
          idx_d   = '0;
          cnt_clr = 1'b1;
        end else if (tc) begin
          if (GUARD_CYC > 0) begin
            state_d  = StGuard;
            cnt_load = 1'b1;
            cnt_val  = GUARD_LD;
          end else begin
            next_slot = 1'b1;
          end
        end
      end
      StGuard: begin
        if (!enable) begin
          state_d = StIdle;
          idx_d   = '0;
          cnt_clr = 1'b1;
        end else if (tc) begin
          next_slot = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
        cnt_clr = 1'b1;
      end
    endcase

    if (next_slot) begin
      state_d  = StScan;
      cnt_load = 1'b1;
      cnt_val  = TICK_LD;
      if (idx_q == LAST_IDX) begin
        // Frame boundary: the only point outside idle where the shadow may change.
        idx_d = '0;
        fs_d  = 1'b1;
        if (ld.load_req) begin
          shadow_d = ld.value_in;
          ack_d    = 1'b1;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    logic seen;
    blank = '0;
    seen  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (shadow_d[DIGIT_W*i +: DIGIT_W] != '0) seen = 1'b1;
      blank[i] = !seen;
    end
`endif
    an_n_d = '1;
    code_d = BLANK_CODE;
    if (state_d == StScan) begin
      an_n_d = ~(NUM_DIGITS'(1) << idx_d);
      code_d = blank[idx_d] ? BLANK_CODE : shadow_d[DIGIT_W*idx_d +: DIGIT_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      shadow_q    <= '0;
      ld.load_ack <= 1'b0;
      frame_start <= 1'b0;
      an_n        <= '1;
      digit_code  <= BLANK_CODE;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      ld.load_ack <= ack_d;
      frame_start <= fs_d;
      an_n        <= an_n_d;
      digit_code  <= code_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: vector table, directed corner cases, random traffic.
module tb_seg_scan_ctrl;
  import seg_scan_pkg::*;

  localparam int unsigned ND     = 4;
  localparam int unsigned TD     = 4;
  localparam int unsigned GC     = 1;
  localparam int unsigned SLOT   = TD + GC;
  localparam int unsigned PERIOD = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [3:0]    digit_code;
  logic [ND-1:0] an_n;
  logic          frame_start;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) ld_if ();

  seg_scan_ctrl #(
    .NUM_DIGITS(ND),
    .TICK_DIV  (TD),
    .GUARD_CYC (GC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .ld         (ld_if),
    .digit_code (digit_code),
    .an_n       (an_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  // Reference model: frame position counted in cycles, display derived arithmetically.
  bit         m_run;
  int         m_t;
  logic [15:0] m_shadow;
  bit         m_ack, m_fs;

  function automatic void model_reset();
    m_run = 0; m_t = 0; m_shadow = '0; m_ack = 0; m_fs = 0;
  endfunction

  function automatic void model_edge(bit e, bit r, logic [15:0] v);
    m_ack = 0;
    m_fs  = 0;
    if (!m_run) begin
      if (r) begin m_shadow = v; m_ack = 1; end
      if (e) begin m_run = 1; m_t = 0; m_fs = 1; end
    end else if (!e) begin
      m_run = 0;
    end else begin
      m_t++;
      if (m_t == PERIOD) begin
        m_t  = 0;
        m_fs = 1;
        if (r) begin m_shadow = v; m_ack = 1; end
      end
    end
  endfunction

  function automatic logic [ND-1:0] exp_an();
    if (!m_run || (m_t % SLOT) >= TD) return '1;
    return ~(ND'(1) << (m_t / SLOT));
  endfunction

  function automatic logic [3:0] exp_code();
    int slot;
    logic [15:0] upper;
    if (!m_run || (m_t % SLOT) >= TD) return 4'hF;
    slot  = m_t / SLOT;
    upper = m_shadow >> (4 * slot);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && upper == 16'h0) return 4'hF;
`endif
    return upper[3:0];
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input bit e, input bit r, input logic [15:0] v);
    enable = e;
    ld_if.load_req = r;
    ld_if.value_in = v;
    @(posedge clk);
    model_edge(e, r, v);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".an_n"}, an_n, exp_an());
    check({tag, ".code"}, digit_code, exp_code());
    check({tag, ".ack"}, ld_if.load_ack, m_ack);
    check({tag, ".fs"}, frame_start, m_fs);
  endtask

  task automatic cyc(input string tag, input bit e, input bit r, input logic [15:0] v);
    step(e, r, v);
    check_model(tag);
  endtask

  typedef struct {
    bit          en;
    bit          req;
    logic [15:0] val;
    logic [3:0]  an;
    logic [3:0]  code;
    bit          ack;
    bit          fs;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit en, bit req, logic [15:0] val, logic [3:0] an,
                              logic [3:0] code, bit ack, bit fs);
    vec_t v;
    v.en = en; v.req = req; v.val = val; v.an = an; v.code = code; v.ack = ack; v.fs = fs;
    vecs.push_back(v);
  endfunction

  initial begin
    int         codes[4];
    int         n;
    bit         req;
    logic [15:0] val;
    bit         en;

    codes = '{4, 3, 2, 1};
    model_reset();
    ld_if.load_req = 1'b0;
    ld_if.value_in = '0;

    // Reset held, then released with enable low.
    repeat (2) @(negedge clk);
    check("rst.an_n", an_n, 4'b1111);
    check("rst.code", digit_code, 4'hF);
    check("rst.ack", ld_if.load_ack, 0);
    check("rst.fs", frame_start, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc("idle", 1'b0, 1'b0, 16'h0);

    // Idle load of 1234, then one full frame plus the wrap.
    add(1'b0, 1'b1, 16'h1234, 4'b1111, 4'hF, 1'b1, 1'b0);
    for (int d = 0; d < 4; d++) begin
      logic [3:0] a;
      a = ~(4'b0001 << d);
      for (int k = 0; k < 4; k++) add(1'b1, 1'b0, 16'h0, a, 4'(codes[d]), 1'b0, (d == 0 && k == 0));
      add(1'b1, 1'b0, 16'h0, 4'b1111, 4'hF, 1'b0, 1'b0);
    end
    add(1'b1, 1'b0, 16'h0, 4'b1110, 4'h4, 1'b0, 1'b1);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].req, vecs[i].val);
      check($sformatf("vec%0d.an_n", i), an_n, vecs[i].an);
      check($sformatf("vec%0d.code", i), digit_code, vecs[i].code);
      check($sformatf("vec%0d.ack", i), ld_if.load_ack, vecs[i].ack);
      check($sformatf("vec%0d.fs", i), frame_start, vecs[i].fs);
    end

    // Mid-frame request: held until the wrap edge.
    for (int i = 0; i < 6; i++) cyc("mid", 1'b1, 1'b0, 16'h0);
    n = 0;
    do begin
      cyc("mid_req", 1'b1, 1'b1, 16'h5678);
      n++;
    end while (!ld_if.load_ack && n < 3 * PERIOD);
    check("mid.ack_latency", n, PERIOD - 6);
    check("mid.ack_with_fs", frame_start, 1);
    check("mid.new_d0", digit_code, 4'h8);
    for (int i = 0; i < PERIOD - 1; i++) cyc("mid_frame", 1'b1, 1'b0, 16'h0);

    // Request rising on the wrap edge.
    check("wrap.pos", m_t, PERIOD - 1);
    cyc("wrap_req", 1'b1, 1'b1, 16'h9ABC);
    check("wrap.ack", ld_if.load_ack, 1);
    check("wrap.d0", digit_code, 4'hC);

    // Enable dropped in digit-2 slot with a request pending.
    for (int i = 0; i < 2 * SLOT + 1; i++) cyc("pre_drop", 1'b1, 1'b0, 16'h0);
    cyc("drop", 1'b0, 1'b1, 16'h0042);
    check("drop.an_n", an_n, 4'b1111);
    check("drop.no_ack", ld_if.load_ack, 0);
    cyc("drop_idle", 1'b0, 1'b1, 16'h0042);
    check("drop.idle_ack", ld_if.load_ack, 1);
    cyc("drop_rel", 1'b0, 1'b0, 16'h0);
    cyc("reen", 1'b1, 1'b0, 16'h0);
    check("reen.fs", frame_start, 1);
    check("reen.an_n", an_n, 4'b1110);
    for (int i = 0; i < 3 * SLOT; i++) cyc("lz42", 1'b1, 1'b0, 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
    check("lz42.d3", digit_code, 4'hF);
`else
    check("lz42.d3", digit_code, 4'h0);
`endif
    check("lz42.d3_an", an_n, 4'b0111);

    // All-zero value: only digit 0 keeps showing.
    cyc("z_drop", 1'b0, 1'b0, 16'h0);
    cyc("z_load", 1'b0, 1'b1, 16'h0000);
    cyc("z_en", 1'b1, 1'b0, 16'h0);
    check("z.d0", digit_code, 4'h0);
    for (int i = 0; i < SLOT; i++) cyc("z_frame", 1'b1, 1'b0, 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
    check("z.d1", digit_code, 4'hF);
`else
    check("z.d1", digit_code, 4'h0);
`endif

    // Asynchronous reset in the middle of a handshake.
    cyc("rst_pre", 1'b1, 1'b1, 16'hBEEF);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.an_n", an_n, 4'b1111);
    check("arst.code", digit_code, 4'hF);
    check("arst.ack", ld_if.load_ack, 0);
    check("arst.fs", frame_start, 0);
    @(negedge clk);
    ld_if.load_req = 1'b0;
    rst_n = 1'b1;
    cyc("arst_idle", 1'b0, 1'b0, 16'h0);

    // Random traffic from a compliant master.
    en  = 1'b1;
    req = 1'b0;
    val = '0;
    for (int i = 0; i < 2000; i++) begin
      if (req && ld_if.load_ack) begin
        req = ($urandom_range(0, 3) == 0);
        val = 16'($urandom);
      end else if (!req) begin
        req = ($urandom_range(0, 7) == 0);
        val = 16'($urandom);
      end
      if ($urandom_range(0, 63) == 0) en = !en;
      cyc("rand", en, req, val);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
